// File: rtl/cam_pkg.sv
// Shared camera-path types: FSM states, default frame geometry, RGB565 layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_pkg;

    // Capture FSM: discard settling frames, wait for enable, then stream.
    typedef enum logic [1:0] {
        SKIP   = 2'd0,
        GATE   = 2'd1,
        ACTIVE = 2'd2
    } cam_state_t;

    // Default sensor window (RGB565 words per line, lines per frame).
    localparam int CAM_H_ACTIVE = 640;
    localparam int CAM_V_ACTIVE = 360;

    // RGB565 field positions, shared with the downstream fusion logic.
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    typedef struct packed {
        logic [RGB_R_MSB-RGB_R_LSB:0] r;
        logic [RGB_G_MSB-RGB_G_LSB:0] g;
        logic [RGB_B_MSB-RGB_B_LSB:0] b;
    } rgb565_t;

endpackage

// File: rtl/cam_edge_det.sv
// Single-edge detector on an already-registered level (RISING=1: 0->1, else 1->0).
// Latency: pulse is combinational from level, valid in the first cycle level differs from its delayed copy.
// Backpressure: none; one pulse per edge.
module cam_edge_det #(
    parameter int RISING = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Previous-cycle copy of the level for edge comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = (RISING != 0) ? (level & ~level_q) : (~level & level_q);

endmodule

// File: rtl/cmos_capture_8to16.sv
// DVP byte-stream capture: skips settling frames, gates frames on capture_en, packs byte pairs into RGB565 words.
// Latency: 2 cmos_pclk cycles pins->outputs for both data and vsync.
// Backpressure: none; the sensor cannot be stalled, cmos_href is a pure write strobe.
module cmos_capture_8to16
    import cam_pkg::*;
#(
    parameter int FRAME_SKIP    = 10,
    parameter int H_ACTIVE      = CAM_H_ACTIVE,
    parameter int V_ACTIVE      = CAM_V_ACTIVE,
    parameter int HI_BYTE_FIRST = 1
) (
    input  logic        cmos_pclk,
    input  logic        sys_rst,
    input  logic        cmos_vsync_i,
    input  logic        cmos_href_i,
    input  logic [7:0]  cmos_data_i,
    input  logic        capture_en,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [15:0] cmos_data,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    localparam logic [8:0]  SKIP_TGT  = 9'(FRAME_SKIP);
    localparam logic [11:0] H_TGT     = 12'(H_ACTIVE);
    localparam logic [10:0] V_TGT     = 11'(V_ACTIVE);
    localparam logic [11:0] PIX_MAX   = 12'hFFF;
    localparam logic [10:0] LINE_MAX  = 11'h7FF;

    logic        vsync_r;
    logic        href_r;
    logic [7:0]  data_r;
    logic        vsync_rise;
    logic        href_fall;

    cam_state_t  state;
    cam_state_t  state_nxt;
    logic [7:0]  skip_cnt;
    logic [7:0]  skip_cnt_nxt;
    logic [8:0]  skip_inc;

    logic        phase;
    logic [7:0]  byte_hold;
    logic [11:0] pixel_cnt;
    logic [10:0] line_cnt;
    logic        word_done;
    logic        out_en;
    logic        end_of_frame;
    rgb565_t     word_pix;

    // Register every sensor pin once before any decision is made on it.
    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            data_r  <= 8'd0;
        end else begin
            vsync_r <= cmos_vsync_i;
            href_r  <= cmos_href_i;
            data_r  <= cmos_data_i;
        end
    end

    cam_edge_det #(.RISING(1)) u_vsync_edge (
        .clk   (cmos_pclk),
        .rst   (sys_rst),
        .level (vsync_r),
        .pulse (vsync_rise)
    );

    cam_edge_det #(.RISING(0)) u_href_edge (
        .clk   (cmos_pclk),
        .rst   (sys_rst),
        .level (href_r),
        .pulse (href_fall)
    );

    // The skip counter is compared after counting the current edge, so the
    // first output-eligible frame is frame FRAME_SKIP (frame 0 at least is always dropped).
    assign skip_inc = {1'b0, skip_cnt} + 9'd1;

    // FSM state register.
    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            state    <= SKIP;
            skip_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_cnt_nxt;
        end
    end

    // FSM next state: only a frame-start edge can move it; capture_en is looked at only there.
    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        if (vsync_rise) begin
            case (state)
                SKIP: begin
                    skip_cnt_nxt = skip_inc[7:0];
                    if (skip_inc >= SKIP_TGT) begin
                        state_nxt = GATE;
                    end
                end
                GATE: begin
                    if (capture_en) begin
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!capture_en) begin
                        state_nxt = GATE;
                    end
                end
                default: state_nxt = SKIP;
            endcase
        end
    end

    // Using the next state lets vsync rise together with the GATE->ACTIVE edge
    // and stay low on the ACTIVE->GATE edge.
    assign out_en       = (state_nxt == ACTIVE);
    assign end_of_frame = vsync_rise && (state == ACTIVE);
    assign word_done    = href_r && phase && !vsync_rise;
    assign word_pix     = (HI_BYTE_FIRST != 0) ? {byte_hold, data_r} : {data_r, byte_hold};

    // Byte pairing, word strobe and per-line checks.
    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            phase     <= 1'b0;
            byte_hold <= 8'd0;
            pixel_cnt <= 12'd0;
            cmos_href <= 1'b0;
            cmos_data <= 16'd0;
            line_err  <= 1'b0;
        end else begin
            cmos_href <= 1'b0;
            line_err  <= 1'b0;
            // A frame edge discards any half-assembled word.
            phase     <= href_r && !vsync_rise && !phase;
            if (href_r && !phase) begin
                byte_hold <= data_r;
            end
            if (word_done) begin
                if (pixel_cnt != PIX_MAX) begin
                    pixel_cnt <= pixel_cnt + 12'd1;
                end
                if (out_en) begin
                    cmos_href <= 1'b1;
                    cmos_data <= word_pix;
                end
            end
            // phase still set here means the line ended on a dangling byte.
            if (href_fall) begin
                pixel_cnt <= 12'd0;
                line_err  <= (state == ACTIVE) && (phase || (pixel_cnt != H_TGT));
            end
        end
    end

    // Frame bookkeeping: line count, end-of-frame pulses, frame counter, gated vsync.
    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            line_cnt   <= 11'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 8'd0;
            cmos_vsync <= 1'b0;
        end else begin
            frame_done <= end_of_frame;
            frame_err  <= end_of_frame && (line_cnt != V_TGT);
            if (end_of_frame) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            cmos_vsync <= vsync_r && out_en;
            if (vsync_rise) begin
                line_cnt <= 11'd0;
            end else if (href_fall && (pixel_cnt != 12'd0) && (line_cnt != LINE_MAX)) begin
                line_cnt <= line_cnt + 11'd1;
            end
        end
    end

endmodule

// File: doc/cmos_capture_8to16.md
Name: cmos_capture_8to16

Overview:
Per-camera DVP capture front end that sits directly upstream of the two-camera splicing stage; one instance per sensor.
- Takes the sensor's 8-bit byte stream and assembles RGB565 words.
- Discards the first FRAME_SKIP frames after reset while sensor exposure and AWB settle.
- Gates whole frames with capture_en.
- Emits a vsync/href/16-bit stream in which href is high exactly on cycles that carry a valid word, so it can drive FIFO write enables directly.

Parameters:
FRAME_SKIP, 10, frames discarded after reset before output is enabled (0 = none)
H_ACTIVE, 640, expected RGB565 words per line
V_ACTIVE, 360, expected lines per frame
HI_BYTE_FIRST, 1, 1: first byte of a pair is [15:8]; 0: first byte is [7:0]

Ports:
cmos_pclk  in  1  sensor pixel clock; the only clock
sys_rst  in  1  synchronous, active-high reset
cmos_vsync_i  in  1  sensor vsync, active high; rising edge = frame start
cmos_href_i  in  1  sensor href, high during active bytes
cmos_data_i  in  8  sensor byte
capture_en  in  1  frame-level output enable
cmos_vsync  out  1  gated, delayed vsync
cmos_href  out  1  word-valid strobe
cmos_data  out  16  RGB565 word, valid when cmos_href=1
frame_done  out  1  1-cycle pulse at the end of every output frame
line_err  out  1  1-cycle pulse: line byte count odd, or word count != H_ACTIVE
frame_err  out  1  1-cycle pulse: line count != V_ACTIVE at frame end
frame_cnt  out  8  count of output frames, wraps at 255->0

Behaviour:
Reset: all outputs 0, FSM=SKIP, skip/pixel/line/frame counters 0, byte phase 0.

Input stage: all sensor inputs are registered once. vsync rising edge is detected on the registered copy.

FSM (transitions on a detected vsync rising edge only):
- SKIP: skip_cnt increments per edge. When skip_cnt==FRAME_SKIP (checked at the edge), go to GATE. FRAME_SKIP=0 enters GATE on the first edge.
- GATE: if capture_en=1 at the edge, go to ACTIVE; otherwise stay. No output.
- ACTIVE: outputs driven.
  - At each edge, if a frame was in progress: pulse frame_done, increment frame_cnt, and compare line_cnt with V_ACTIVE (pulse frame_err on mismatch, same cycle as frame_done).
  - If capture_en=0 at that edge, go to GATE.
  - capture_en changes mid-frame are ignored until the next edge.

Assembly:
- Byte phase toggles on each registered-href-high cycle and is forced to 0 while href is low.
- Phase 0 byte is held. Phase 1 completes the word.
- cmos_href pulses for 1 cycle per word, in the cycle after the phase-1 byte is in the input register.
- Latency is 2 cmos_pclk cycles from pins to output, for both data and vsync.
- cmos_vsync = registered vsync delayed to match data latency, forced 0 outside ACTIVE.
  - On the GATE->ACTIVE edge, the high pulse starts on that same edge.

Line check (on href falling edge):
- Odd byte: the dangling byte is dropped, no word emitted, line_err pulses.
- Word count != H_ACTIVE: line_err pulses.
- line_cnt increments per line with ≥1 word and saturates at 2047.
- pixel_cnt (12-bit) saturates at 4095 and clears on href falling.
- Error pulses are emitted only in ACTIVE.

Boundaries:
- href high across a vsync edge: phase resets and the partial word is dropped.
- frame_done and line_err may pulse in the same cycle.
- Reset mid-line or mid-frame: outputs drop to 0 the next cycle, FSM returns to SKIP, and the full skip count is redone.

Widths: skip_cnt 8 bits, line_cnt 11 bits, pixel_cnt 12 bits. FRAME_SKIP ≤ 255, H_ACTIVE ≤ 4095, V_ACTIVE ≤ 2047.

Decomposition:
Shared package cam_pkg holds:
- FSM state enum {SKIP, GATE, ACTIVE}
- H_ACTIVE/V_ACTIVE defaults
- RGB565 field ranges (R [15:11], G [10:5], B [4:0]), also used by the fusion logic downstream

One sub-module, cam_edge_det (registered rising/falling edge detector), is instantiated for vsync and href.

Test Plan:
1. FRAME_SKIP=2, capture_en=1, 4 frames of 640x360 → no cmos_href during frames 0–1. Frames 2–3 each give 640 strobes/line and 360 lines, frame_done pulses twice, frame_cnt=2, no errors.
2. Bytes 0xF8,0x1F with HI_BYTE_FIRST=1 → cmos_data=16'hF81F, 2 cycles after the second byte. HI_BYTE_FIRST=0 → 16'h1FF8.
3. One line of 1279 bytes → 639 words, one line_err pulse at href fall, dangling byte not emitted.
4. Frame with 359 lines → frame_err together with frame_done at the next vsync rise. frame_cnt still increments.
5. capture_en dropped mid-frame 3 → frame 3 completes fully, frame 4 has no output and cmos_vsync stays 0. Re-raising capture_en before frame 5's vsync restores output from frame 5.
6. sys_rst for 1 cycle mid-line in ACTIVE → all outputs 0 the next cycle and frame_cnt=0. Output resumes only after FRAME_SKIP further vsync edges.
